// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, round-count constants, S-box and ShiftRows helpers
package aes_pkg;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOOK = 2'd1,
        ST_MIX  = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_t;

    // Entry for input byte a sits at bits [2047-8a -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic byte_t sbox(input byte_t a);
        return SBOX_TABLE[{~a, 3'b000} +: 8];
    endfunction

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte b = 4*column + row; returns the pre-ShiftRows byte landing at b.
    function automatic int shift_rows_src(input int b);
        int row;
        int col;
        row = b % 4;
        col = b / 4;
        return 4 * ((col + row) % 4) + row;
    endfunction

    function automatic block_t shift_rows(input block_t blk);
        block_t res;
        res = '0;
        for (int b = 0; b < 16; b++) begin
            res[127-8*b -: 8] = blk[127-8*shift_rows_src(b) -: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_round_fsm.sv
// rtl/aes_round_fsm.sv - round sequencer: IDLE/LOOK/MIX/DONE, round counter and handshakes
module aes_round_fsm
    import aes_pkg::*;
#(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              out_ready,
    output logic              in_ready,
    output logic              out_valid,
    output logic [KIDX_W-1:0] key_idx,
    output logic              load_in,
    output logic              look_en,
    output logic              mix_round,
    output logic              mix_final
);

    localparam logic [KIDX_W-1:0] NR_K = KIDX_W'(NR);

    fsm_state_t        state_q, state_d;
    logic [KIDX_W-1:0] rnd_q, rnd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        key_idx   = rnd_q;
        load_in   = 1'b0;
        look_en   = 1'b0;
        mix_round = 1'b0;
        mix_final = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                key_idx  = '0;
                if (in_valid) begin
                    load_in = 1'b1;
                    rnd_d   = KIDX_W'(1);
                    state_d = ST_LOOK;
                end
            end
            ST_LOOK: begin
                look_en = 1'b1;
                state_d = ST_MIX;
            end
            ST_MIX: begin
                if (rnd_q == NR_K) begin
                    mix_final = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    mix_round = 1'b1;
                    rnd_d     = rnd_q + KIDX_W'(1);
                    state_d   = ST_LOOK;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/aes_sbox_word.sv
// rtl/aes_sbox_word.sv - four parallel AES S-boxes over one 32-bit word
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] w_in,
    output logic [31:0] w_out
);

    assign w_out = {sbox(w_in[31:24]), sbox(w_in[23:16]),
                    sbox(w_in[15:8]),  sbox(w_in[7:0])};

endmodule

// File: rtl/table_lookup.sv
// rtl/table_lookup.sv - registered T0..T3 lookups of one state column (row j of w_in -> Tj)
module table_lookup
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] w_in,
    output logic [31:0] p0,
    output logic [31:0] p1,
    output logic [31:0] p2,
    output logic [31:0] p3
);

    logic [31:0] sb;
    byte_t       s  [4];
    byte_t       x2 [4];
    byte_t       x3 [4];
    logic [31:0] p0_d, p1_d, p2_d, p3_d;
    logic [31:0] p0_q, p1_q, p2_q, p3_q;

    aes_sbox_word u_sbox (
        .w_in  (w_in),
        .w_out (sb)
    );

    for (genvar j = 0; j < 4; j++) begin : g_lane
        assign s[j]  = sb[31-8*j -: 8];
        assign x2[j] = xtime(s[j]);
        assign x3[j] = x2[j] ^ s[j];
    end

    // Tj is T0 = {2S, S, S, 3S} rotated right by j bytes.
    always_comb begin
        p0_d = p0_q;
        p1_d = p1_q;
        p2_d = p2_q;
        p3_d = p3_q;
        if (en) begin
            p0_d = {x2[0], s[0],  s[0],  x3[0]};
            p1_d = {x3[1], x2[1], s[1],  s[1]};
            p2_d = {s[2],  x3[2], x2[2], s[2]};
            p3_d = {s[3],  s[3],  x3[3], x2[3]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_q <= '0;
            p1_q <= '0;
            p2_q <= '0;
            p3_q <= '0;
        end else begin
            p0_q <= p0_d;
            p1_q <= p1_d;
            p2_q <= p2_d;
            p3_q <= p3_d;
        end
    end

    assign p0 = p0_q;
    assign p1 = p1_q;
    assign p2 = p2_q;
    assign p3 = p3_q;

endmodule

// File: rtl/aes_round_iter.sv
// rtl/aes_round_iter.sv - iterative AES-128/192/256 encryptor over one T-table round datapath
module aes_round_iter
    import aes_pkg::*;
#(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      state_in,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [127:0]      round_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out
);

    if (NR != NR_AES128 && NR != NR_AES192 && NR != NR_AES256) begin : g_bad_nr
        $error("aes_round_iter: NR must be 10, 12 or 14");
    end
    if ((1 << KIDX_W) <= NR) begin : g_bad_kidx
        $error("aes_round_iter: KIDX_W too narrow to index round NR");
    end

    logic   load_in, look_en, mix_round, mix_final;
    block_t state_q, state_d;
    block_t sb_q, sb_d;
    block_t out_q, out_d;
    block_t round_blk, final_blk;
    word_t  sbw [4];
    word_t  p   [4][4];
    word_t  k   [4];
    word_t  z   [4];

    aes_round_fsm #(
        .NR     (NR),
        .KIDX_W (KIDX_W)
    ) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .key_idx   (key_idx),
        .load_in   (load_in),
        .look_en   (look_en),
        .mix_round (mix_round),
        .mix_final (mix_final)
    );

    // p[i][j] = Tj[row j of column i]; column i of the round output gathers the
    // diagonal starting at column i, which folds ShiftRows into the lookup.
    for (genvar i = 0; i < 4; i++) begin : g_col
        table_lookup u_tl (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (look_en),
            .w_in  (state_q[127-32*i -: 32]),
            .p0    (p[i][0]),
            .p1    (p[i][1]),
            .p2    (p[i][2]),
            .p3    (p[i][3])
        );

        aes_sbox_word u_sbw (
            .w_in  (state_q[127-32*i -: 32]),
            .w_out (sbw[i])
        );

        assign k[i] = round_key[127-32*i -: 32];
        assign z[i] = p[i][0] ^ p[(i+1)%4][1] ^ p[(i+2)%4][2] ^ p[(i+3)%4][3] ^ k[i];
    end

    assign round_blk = {z[0], z[1], z[2], z[3]};
    assign final_blk = shift_rows(sb_q) ^ round_key;

    always_comb begin
        state_d = state_q;
        sb_d    = sb_q;
        out_d   = out_q;
        if (look_en) begin
            sb_d = {sbw[0], sbw[1], sbw[2], sbw[3]};
        end
        if (load_in) begin
            state_d = state_in ^ round_key;
        end else if (mix_round) begin
            state_d = round_blk;
        end else if (mix_final) begin
            state_d = final_blk;
            out_d   = final_blk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            sb_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            sb_q    <= sb_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_aes_round_iter.sv
// tb/tb_aes_round_iter.sv - directed and randomized checks of aes_round_iter against a byte-level AES model
module tb_aes_round_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         iv10, ir10, ov10, or10;
    logic [127:0] si10, rkin10, out10;
    logic [3:0]   ki10;
    logic         iv14, ir14, ov14, or14;
    logic [127:0] si14, rkin14, out14;
    logic [3:0]   ki14;

    logic [127:0] rk10 [0:15];
    logic [127:0] rk14 [0:15];
    logic [7:0]   sb_ref [256];

    assign rkin10 = rk10[ki10];
    assign rkin14 = rk14[ki14];

    aes_round_iter #(.NR(10), .KIDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv10), .in_ready(ir10), .state_in(si10),
        .key_idx(ki10), .round_key(rkin10), .out_valid(ov10), .out_ready(or10), .out(out10)
    );

    aes_round_iter #(.NR(14), .KIDX_W(4)) dut14 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv14), .in_ready(ir14), .state_in(si14),
        .key_idx(ki14), .round_key(rkin14), .out_valid(ov14), .out_ready(or14), .out(out14)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            repeat (254) inv = gmul(inv, 8'(x));
            sb_ref[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb_ref[w[31:24]], sb_ref[w[23:16]], sb_ref[w[15:8]], sb_ref[w[7:0]]};
    endfunction

    // Key is left-aligned in 256 bits; nk = 4 fills rk10, nk = 8 fills rk14.
    task automatic expand_key(input logic [255:0] key, input int nk);
        logic [31:0] w [0:59];
        logic [31:0] temp;
        logic [7:0]  rcon;
        int          nr;
        nr = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = subw({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                temp = subw(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r <= nr; r++) begin
            if (nk == 8) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input bit use14);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] blk;
        int           nr;
        nr  = use14 ? 14 : 10;
        blk = pt ^ (use14 ? rk14[0] : rk10[0]);
        for (int rd = 1; rd <= nr; rd++) begin
            for (int b = 0; b < 16; b++) s[b] = sb_ref[blk[127-8*b -: 8]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++)
                    t[4*c+rw] = s[4*((c+rw)%4)+rw];
            if (rd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int b = 0; b < 16; b++) blk[127-8*b -: 8] = t[b];
            blk = blk ^ (use14 ? rk14[rd] : rk10[rd]);
        end
        return blk;
    endfunction

    // Offers one block, then counts cycles from the accept cycle (0) to out_valid.
    // Expected key index in cycle n of the run is ceil(n/2), never above NR.
    task automatic run_block(input bit use14, input logic [127:0] pt, output int lat,
                             output logic [127:0] ct, output bit trace_ok);
        int n;
        int nr;
        logic [3:0] ki;
        nr = use14 ? 14 : 10;
        trace_ok = 1'b1;
        n = 0;
        while (!(use14 ? ir14 : ir10) && n < 50) begin
            tick();
            n++;
        end
        if (use14) begin iv14 = 1'b1; si14 = pt; end
        else       begin iv10 = 1'b1; si10 = pt; end
        if ((use14 ? ki14 : ki10) !== 4'd0) trace_ok = 1'b0;
        tick();
        iv10 = 1'b0;
        iv14 = 1'b0;
        lat = 1;
        while ((use14 ? ov14 : ov10) !== 1'b1 && lat < 100) begin
            ki = use14 ? ki14 : ki10;
            if (int'(ki) != (lat + 1) / 2 || int'(ki) > nr) trace_ok = 1'b0;
            tick();
            lat++;
        end
        ct = use14 ? out14 : out10;
    endtask

    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        logic [127:0] ct;
        logic [127:0] held;
        bit           tok;
        bit           hold_ok;
        bit           acc;
        int           idx;
        int           cyc;
        logic [127:0] pts [3];
        logic [127:0] exps [3];
        logic [127:0] outs [$];
        int           ocyc [$];

        rst_n = 1'b0;
        iv10 = 1'b0; or10 = 1'b0; si10 = '0;
        iv14 = 1'b0; or14 = 1'b0; si14 = '0;
        build_sbox();
        repeat (3) tick();

        check("rst_in_ready",  128'(ir10), 128'(1));
        check("rst_out_valid", 128'(ov10), 128'(0));
        check("rst_out",       out10,      128'(0));
        check("rst_key_idx",   128'(ki10), 128'(0));
        rst_n = 1'b1;
        tick();

        expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        run_block(1'b0, PT_FIPS, lat, ct, tok);
        check("c1_ct",            ct,          CT_C1);
        check("c1_latency",       128'(lat),   128'(21));
        check("c1_key_idx_trace", 128'(tok),   128'(1));

        hold_ok = 1'b1;
        held = out10;
        for (int i = 0; i < 10; i++) begin
            iv10 = i[0];
            si10 = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (out10 !== held || ov10 !== 1'b1 || ir10 !== 1'b0) hold_ok = 1'b0;
        end
        iv10 = 1'b0;
        check("bp_hold_stable", 128'(hold_ok), 128'(1));
        or10 = 1'b1;
        tick();
        or10 = 1'b0;
        check("bp_release_out_valid", 128'(ov10), 128'(0));
        check("bp_release_in_ready",  128'(ir10), 128'(1));

        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        run_block(1'b1, PT_FIPS, lat, ct, tok);
        check("nr14_ct",            ct,        CT_C3);
        check("nr14_latency",       128'(lat), 128'(29));
        check("nr14_key_idx_trace", 128'(tok), 128'(1));
        or14 = 1'b1;
        tick();
        or14 = 1'b0;

        iv10 = 1'b1;
        si10 = PT_FIPS;
        tick();
        iv10 = 1'b0;
        repeat (9) tick();
        check("mid_key_idx_round5", 128'(ki10), 128'(5));
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  128'(ir10), 128'(1));
        check("mid_rst_out_valid", 128'(ov10), 128'(0));
        check("mid_rst_out",       out10,      128'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_block(1'b0, PT_FIPS, lat, ct, tok);
        check("post_rst_c1_ct",      ct,        CT_C1);
        check("post_rst_c1_latency", 128'(lat), 128'(21));
        or10 = 1'b1;
        tick();

        expand_key({$urandom, $urandom, $urandom, $urandom, 128'h0}, 4);
        for (int i = 0; i < 3; i++) begin
            pts[i]  = {$urandom, $urandom, $urandom, $urandom};
            exps[i] = ref_encrypt(pts[i], 1'b0);
        end
        idx  = 0;
        iv10 = 1'b1;
        si10 = pts[0];
        cyc  = 0;
        while (outs.size() < 3 && cyc < 300) begin
            acc = iv10 && ir10;
            if (ov10) begin
                outs.push_back(out10);
                ocyc.push_back(cyc);
            end
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 3) si10 = pts[idx];
                else         iv10 = 1'b0;
            end
        end
        iv10 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b_ct%0d", i), (i < outs.size()) ? outs[i] : 128'hx, exps[i]);
        end
        check("b2b_first_latency", 128'((ocyc.size() > 0) ? ocyc[0] : -1), 128'(21));
        for (int i = 1; i < 3; i++) begin
            check($sformatf("b2b_spacing%0d", i),
                  128'((ocyc.size() > i) ? ocyc[i] - ocyc[i-1] : -1), 128'(22));
        end
        or10 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_round_iter.md
Name: aes_round_iter

Overview:
Iterative AES-128/192/256 encryption engine. It holds a 128-bit state register and loops one T-table round datapath over NR rounds, then runs a final round (SubBytes/ShiftRows/AddRoundKey, no MixColumns).
Round keys come from an external key-schedule store, indexed by this block. Input and output use valid/ready handshakes.
This block is the sequenced, multi-round successor of the single-round T-table datapath and sits between the block-cipher front end and the output formatter.

Parameters:
NR, 10, number of rounds; legal values 10/12/14 (AES-128/192/256); any other value is a build-time error.
KIDX_W, 4, width of the round-key index; must satisfy 2^KIDX_W > NR.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  plaintext block present
in_ready  out  1  engine can accept a block
state_in  in  128  plaintext block, word 0 = bits [127:96]
key_idx  out  KIDX_W  round-key index being requested
round_key  in  128  key for key_idx, valid combinationally in the same cycle
out_valid  out  1  ciphertext present
out_ready  in  1  consumer accepts ciphertext
out  out  128  ciphertext, held stable while out_valid && !out_ready

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, state=0, out=0, out_valid=0, in_ready=1, key_idx=0, round counter=0.
- FSM has four states: IDLE, LOOK, MIX, DONE.
- IDLE:
  - in_ready=1 and key_idx=0.
  - On in_valid: state <= state_in ^ round_key (initial AddRoundKey), rnd <= 1, go to LOOK.
- LOOK:
  - The table_lookup instances sample the state words. Their outputs are valid one clock later.
  - key_idx=rnd. Go to MIX.
- MIX:
  - key_idx=rnd.
  - If rnd<NR: state <= z0..z3, where
    - z0 = p00^p11^p22^p33^k0
    - z1 = p03^p10^p21^p32^k1
    - z2 = p02^p13^p20^p31^k2
    - z3 = p01^p12^p23^p30^k3
    - k = round_key.
    - Then rnd <= rnd+1 and go to LOOK.
  - If rnd==NR: state <= ShiftRows(SubBytes(state)) ^ round_key, taken from the registered final-round S-box outputs. Go to DONE.
- DONE:
  - out = state and out_valid=1.
  - On out_ready: out_valid <= 0 and go to IDLE.
  - in_ready=0 in DONE, so there is no same-cycle reload.
- Latency: accept edge to out_valid = 2*NR+1 clocks (21 for NR=10).
- Throughput: one block per 2*NR+2 clocks with out_ready held high.
- in_ready is 0 in LOOK, MIX and DONE. in_valid in those states is ignored, and state_in may change freely.
- key_idx changes only on FSM transitions. round_key is sampled only in IDLE on accept, and in MIX.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-operation aborts the block immediately, with no partial output. The next accept after reset behaves as from power-up.
- Byte/word order follows FIPS-197 column-major: word i = column i, MSB byte = row 0.

Decomposition:
- Shared package aes_pkg:
  - NR_AES128/192/256 constants.
  - word/block typedefs (32b, 128b).
  - FSM state enum.
  - Function for ShiftRows byte mapping.
- Sub-modules:
  - Reuse the existing table_lookup (four instances, registered).
  - Reuse the existing 4-byte S-box word module (four instances) for the final round.
  - One natural new sub-module: aes_round_fsm (state/rnd counter/handshake).

Test Plan:
- FIPS-197 C.1: NR=10, state_in=00112233445566778899aabbccddeeff, bench key model returns the schedule of 000102030405060708090a0b0c0d0e0f -> out=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 21 clocks after accept.
- NR=14 build, key 000102...1f, same plaintext -> out=8ea2b7ca516745bfeafc49904b496089, latency 29.
- Backpressure: hold out_ready=0 for 10 clocks after out_valid -> out stable, in_ready=0, in_valid pulses ignored. Release -> IDLE the next clock, in_ready=1.
- key_idx trace for NR=10 -> 0 at accept, then 1,1,2,2,...,10,10; no value >NR.
- Reset mid-run: deassert rst_n in round 5 -> out_valid=0, in_ready=1 asynchronously. A fresh C.1 run then yields the correct ciphertext.
- Back-to-back: 3 random blocks, out_ready=1, in_valid held -> outputs match the reference model in order, spacing 22 clocks.
